skewed_chunk_adder: RTL and testbench

// - Pipelined WIDTH-bit adder operating on skewed (diagonal) operands split into CHUNK-bit chunks.
// - Chunk i of each operand arrives i cycles after chunk 0, LSB chunk first.
// - Adds one chunk per stage and registers the inter-chunk carry, so the critical path is one CHUNK-bit add.
// - Sits between the operand skewing stage (shifter) and the result deskewing stage (unshifter).
// - End-to-end latency of shifter + this block + unshifter is ceil(WIDTH/CHUNK)-1 cycles.

---
 rtl/skewed_chunk_adder.sv | 79 +++++++
 tb/tb_skewed_chunk_adder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/skewed_chunk_adder.sv
// ---------------------------------------------------------------------------
// skewed_chunk_adder
//
// Pipelined WIDTH-bit adder for diagonally skewed operands. The operands are
// split into CHUNK-bit chunks, and chunk i arrives i cycles after chunk 0
// (LSB chunk first). Each chunk is added combinationally with the carry that
// was registered from the previous chunk one cycle earlier, so the critical
// path is a single CHUNK-bit add. The block adds no latency of its own: out
// chunk i carries the same skew as in1/in2 chunk i, and out[WIDTH] is timed
// with the last chunk.
//
// Ports
//   clk  in   1        rising-edge clock
//   rst  in   1        asynchronous active-high reset, clears the carry flops
//   en   in   1        carry registers advance only while en=1
//   in1  in   WIDTH    skewed operand A
//   in2  in   WIDTH    skewed operand B (same skew as in1)
//   out  out  WIDTH+1  skewed sum, out[WIDTH] = final carry-out
// ---------------------------------------------------------------------------
module skewed_chunk_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH:0]   out
);

    localparam int unsigned N = (WIDTH + CHUNK - 1) / CHUNK;

    // Carry-in and carry-out of every chunk.
    logic [N-1:0] cin;
    logic [N-1:0] co;

    for (genvar g = 0; g < N; g++) begin : g_chunk
        localparam int unsigned LO = g * CHUNK;
        localparam int unsigned HI = (LO + CHUNK > WIDTH) ? WIDTH : LO + CHUNK;
        localparam int unsigned CW = HI - LO;

        logic [CW:0] sum;

        always_comb begin
            sum = {1'b0, in1[HI-1:LO]} + {1'b0, in2[HI-1:LO]} + {{CW{1'b0}}, cin[g]};
        end

        assign out[HI-1:LO] = sum[CW-1:0];
        assign co[g]        = sum[CW];
    end

    // The carry out of the last chunk is the result MSB; it is never stored.
    assign out[WIDTH] = co[N-1];

    if (N > 1) begin : g_carry
        logic [N-2:0] carry_q;
        logic [N-2:0] carry_d;

        always_comb begin
            carry_d = co[N-2:0];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                carry_q <= '0;
            end else if (en) begin
                carry_q <= carry_d;
            end
        end

        // Chunk 0 never has a carry-in; chunk i takes the carry chunk i-1
        // produced one cycle ago, which matches the one-cycle operand skew.
        assign cin = {carry_q, 1'b0};
    end else begin : g_nocarry
        assign cin = 1'b0;
    end

endmodule

// File: tb/tb_skewed_chunk_adder.sv
module tb_skewed_chunk_adder;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CHUNK = 3;
    localparam int unsigned N     = 3;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH:0]   out;

    skewed_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .in1 (in1),
        .in2 (in2),
        .out (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Skew/deskew harness state, index = age in cycles (0 = newest operand).
    logic [WIDTH-1:0] ah   [N];
    logic [WIDTH-1:0] bh   [N];
    logic             vh   [N];
    logic [WIDTH:0]   eh   [N];
    logic [WIDTH:0]   part [N];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 9'h%03h required 9'h%03h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic clear_hist();
        for (int k = 0; k < N; k++) begin
            ah[k] = '0; bh[k] = '0; vh[k] = 1'b0; eh[k] = '0; part[k] = '0;
        end
    endtask

    // One enabled pipeline cycle: shift the skew line, drive the skewed
    // operands, collect the chunk each in-flight result finishes this cycle.
    task automatic step(input logic valid, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH:0] exp,
                        input string name);
        @(negedge clk);
        for (int k = N - 1; k > 0; k--) begin
            ah[k] = ah[k-1]; bh[k] = bh[k-1]; vh[k] = vh[k-1];
            eh[k] = eh[k-1]; part[k] = part[k-1];
        end
        ah[0] = a; bh[0] = b; vh[0] = valid; eh[0] = exp; part[0] = '0;
        in1 = {ah[2][7:6], ah[1][5:3], ah[0][2:0]};
        in2 = {bh[2][7:6], bh[1][5:3], bh[0][2:0]};
        en  = 1'b1;
        #2;
        part[0][2:0] = out[2:0];
        part[1][5:3] = out[5:3];
        part[2][8:6] = out[8:6];
        if (vh[2]) check(name, part[2], eh[2]);
    endtask

    task automatic flush();
        step(1'b0, '0, '0, '0, "flush");
        step(1'b0, '0, '0, '0, "flush");
    endtask

    initial begin
        vecs[0] = '{8'hFF, 8'h01, 9'h100};
        vecs[1] = '{8'h00, 8'h00, 9'h000};
        vecs[2] = '{8'h80, 8'h80, 9'h100};
        vecs[3] = '{8'hFF, 8'hFF, 9'h1FE};
        vecs[4] = '{8'h12, 8'h21, 9'h033};
        vecs[5] = '{8'hA5, 8'h5A, 9'h0FF};
        vecs[6] = '{8'h3F, 8'h01, 9'h040};
        vecs[7] = '{8'hC0, 8'h40, 9'h100};
        vecs[8] = '{8'h07, 8'h01, 9'h008};
        vecs[9] = '{8'h38, 8'h08, 9'h040};

        clear_hist();
        rst = 1'b1; en = 1'b0; in1 = '0; in2 = '0;
        #3;
        check("reset_zero", out, 9'h000);
        in1 = 8'hFF; in2 = 8'h01;
        #1;
        // Chunkwise sums without carry propagation: 0, 7, 3.
        check("reset_no_propagate", out, 9'h0F8);
        @(negedge clk);
        rst = 1'b0; in1 = '0; in2 = '0;

        // Back-to-back table stream (first three form the carry-leak pattern).
        for (int i = 0; i < 10; i++) step(1'b1, vecs[i].a, vecs[i].b, vecs[i].exp, "table");
        flush();

        // Mid-stream asynchronous reset with both carries set.
        for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 8'hFF, 9'h1FE, "pre_reset");
        @(negedge clk);
        in1 = '0; in2 = '0;
        #1;
        check("carries_set", out, 9'h048);
        rst = 1'b1;
        #1;
        check("async_clear", out, 9'h000);
        clear_hist();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'hFF, 8'h01, 9'h100, "after_reset");
        step(1'b1, 8'h12, 8'h21, 9'h033, "after_reset");
        flush();

        // Enable hold: 3 cycles with en=0 and garbage on the inputs.
        step(1'b1, 8'hFF, 8'h01, 9'h100, "en_hold");
        step(1'b1, 8'h3F, 8'h01, 9'h040, "en_hold");
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            en = 1'b0; in1 = '0; in2 = '0;
            #2;
            check("hold_carries", out, 9'h048);
        end
        step(1'b1, 8'hA5, 8'h5A, 9'h0FF, "en_resume");
        flush();

        // Random harness: one independent addition per cycle.
        for (int r = 0; r < 200; r++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom_range(0, 255));
            rb = WIDTH'($urandom_range(0, 255));
            step(1'b1, ra, rb, {1'b0, ra} + {1'b0, rb}, "random");
        end
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
